// File: rtl/mips_pkg.sv
// Constants and types shared by the MIPS pipeline stages.
// The MEM/WB field bundle lives here so that every stage sees one layout.
package mips_pkg;

   localparam int WORD_W = 32;
   localparam int REG_AW = 5;

   typedef struct packed {
      logic              reg_write;
      logic              mem_to_reg;
      logic [WORD_W-1:0] read_data;
      logic [WORD_W-1:0] alu_out;
      logic [REG_AW-1:0] write_reg;
   } wb_fields_t;

   // Only word accesses exist, so any nonzero byte offset on a memory op is an error.
   function automatic logic is_misaligned(input logic       mem_write,
                                          input logic       mem_to_reg,
                                          input logic [1:0] addr_lo);
      return (mem_write | mem_to_reg) & (addr_lo != 2'b00);
   endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// EX/MEM inputs and MEM/WB outputs of the memory stage, bundled as one port.
// master = upstream/downstream pipeline side, slave = the memory stage itself.
interface mem_wb_stage_if;
   import mips_pkg::*;

   logic              RegWriteM;
   logic              MemtoRegM;
   logic              MemWriteM;
   logic [WORD_W-1:0] AluOutM;
   logic [WORD_W-1:0] WriteDataM;
   logic [REG_AW-1:0] WriteRegM;

   logic              RegWriteW;
   logic              MemtoRegW;
   logic [WORD_W-1:0] ReadDataW;
   logic [WORD_W-1:0] AluOutW;
   logic [REG_AW-1:0] WriteRegW;
   logic [WORD_W-1:0] ResultW;
   logic              AlignErr;

   modport master (
      output RegWriteM, MemtoRegM, MemWriteM, AluOutM, WriteDataM, WriteRegM,
      input  RegWriteW, MemtoRegW, ReadDataW, AluOutW, WriteRegW, ResultW, AlignErr
   );

   modport slave (
      input  RegWriteM, MemtoRegM, MemWriteM, AluOutM, WriteDataM, WriteRegM,
      output RegWriteW, MemtoRegW, ReadDataW, AluOutW, WriteRegW, ResultW, AlignErr
   );

endinterface

// File: rtl/mem_wb_stage_data_mem.sv
// Word-addressed data memory: combinational read, write on the rising edge.
// Writes are suppressed while rst is low; contents are never cleared.
module data_mem
   import mips_pkg::*;
#(
   parameter  int DEPTH = 256,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [AW-1:0]     idx,
   input  logic [WORD_W-1:0] wd,
   output logic [WORD_W-1:0] rd
);

   if ((DEPTH < 4) || (DEPTH > 65536) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("data_mem: DEPTH must be a power of two in 4..65536");
   end

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we && rst) begin
         mem[idx] <= wd;
      end
   end

   // Read sees the pre-edge word, giving read-before-write on a same-index collision.
   assign rd = mem[idx];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage plus MEM/WB pipeline register: word load/store, alignment check,
// W register bank, sticky alignment error and the writeback result mux.
module mem_wb_stage
   import mips_pkg::*;
#(
   parameter int DEPTH = 256
) (
   input  logic          clk,
   input  logic          rst,
   mem_wb_stage_if.slave bus
);

   localparam int AW = $clog2(DEPTH);

   logic              misaligned;
   logic [AW-1:0]     mem_idx;
   logic              mem_we;
   logic [WORD_W-1:0] mem_rd;

   wb_fields_t        wb_d;
   wb_fields_t        wb_q;
   logic              align_err_d;
   logic              align_err_q;

   always_comb begin
      misaligned = is_misaligned(bus.MemWriteM, bus.MemtoRegM, bus.AluOutM[1:0]);
      // Upper address bits are dropped, so addresses wrap modulo DEPTH*4.
      mem_idx    = bus.AluOutM[AW+1:2];
      mem_we     = bus.MemWriteM & ~misaligned;
   end

   data_mem #(
      .DEPTH (DEPTH)
   ) u_data_mem (
      .clk (clk),
      .rst (rst),
      .we  (mem_we),
      .idx (mem_idx),
      .wd  (bus.WriteDataM),
      .rd  (mem_rd)
   );

   always_comb begin
      wb_d            = wb_q;
      align_err_d     = align_err_q;

      wb_d.reg_write  = bus.RegWriteM & ~misaligned;
      wb_d.mem_to_reg = bus.MemtoRegM;
      wb_d.read_data  = mem_rd;
      wb_d.alu_out    = bus.AluOutM;
      wb_d.write_reg  = bus.WriteRegM;

      if (misaligned) begin
         align_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_q        <= '0;
         align_err_q <= 1'b0;
      end else begin
         wb_q        <= wb_d;
         align_err_q <= align_err_d;
      end
   end

   assign bus.RegWriteW = wb_q.reg_write;
   assign bus.MemtoRegW = wb_q.mem_to_reg;
   assign bus.ReadDataW = wb_q.read_data;
   assign bus.AluOutW   = wb_q.alu_out;
   assign bus.WriteRegW = wb_q.write_reg;
   assign bus.AlignErr  = align_err_q;
   assign bus.ResultW   = wb_q.mem_to_reg ? wb_q.read_data : wb_q.alu_out;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vector table, reset sequences,
// and randomized traffic against a word-array reference model.
module tb_mem_wb_stage;
   import mips_pkg::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   mem_wb_stage_if bus ();

   mem_wb_stage #(
      .DEPTH (256)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        rw;
      logic        m2r;
      logic        mw;
      logic [31:0] alu;
      logic [31:0] wd;
      logic [4:0]  wr;
      logic        chk_rd;
      logic [31:0] exp_rd;
      logic        exp_rw;
      logic        exp_err;
      logic [31:0] exp_res;
   } vec_t;

   vec_t vecs [13];

   logic [31:0] mdl_mem   [256];
   bit          mdl_known [256];
   bit          mdl_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rw, input logic m2r, input logic mw,
                        input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr);
      bus.RegWriteM  = rw;
      bus.MemtoRegM  = m2r;
      bus.MemWriteM  = mw;
      bus.AluOutM    = alu;
      bus.WriteDataM = wd;
      bus.WriteRegM  = wr;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, ".RegWriteW"}, 32'(bus.RegWriteW), 32'd0);
      chk({tag, ".MemtoRegW"}, 32'(bus.MemtoRegW), 32'd0);
      chk({tag, ".ReadDataW"}, bus.ReadDataW, 32'd0);
      chk({tag, ".AluOutW"},   bus.AluOutW,   32'd0);
      chk({tag, ".WriteRegW"}, 32'(bus.WriteRegW), 32'd0);
      chk({tag, ".ResultW"},   bus.ResultW,   32'd0);
      chk({tag, ".AlignErr"},  32'(bus.AlignErr), 32'd0);
   endtask

   initial begin
      // rw, m2r, mw, alu, wd, wr, chk_rd, exp_rd, exp_rw, exp_err, exp_res
      vecs[0]  = '{1'b0, 1'b0, 1'b1, 32'h10,       32'hDEADBEEF, 5'd0,  1'b0, 32'h0,        1'b0, 1'b0, 32'h10};
      vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h10,       32'h0,        5'd8,  1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'hDEADBEEF};
      vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h10,       32'h11111111, 5'd0,  1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h10};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h10,       32'h22222222, 5'd0,  1'b1, 32'h11111111, 1'b0, 1'b0, 32'h10};
      vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'h10,       32'h0,        5'd3,  1'b1, 32'h22222222, 1'b1, 1'b0, 32'h22222222};
      vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'h13,       32'hBAD0BAD0, 5'd4,  1'b1, 32'h22222222, 1'b0, 1'b1, 32'h13};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h10,       32'h0,        5'd5,  1'b1, 32'h22222222, 1'b1, 1'b1, 32'h22222222};
      vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h12,       32'h0,        5'd6,  1'b1, 32'h22222222, 1'b0, 1'b1, 32'h22222222};
      vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h12345678, 32'hFFFFFFFF, 5'd9,  1'b0, 32'h0,        1'b1, 1'b1, 32'h12345678};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h400,      32'hA5A5A5A5, 5'd0,  1'b0, 32'h0,        1'b0, 1'b1, 32'h400};
      vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h0,        32'h0,        5'd10, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b1, 32'hA5A5A5A5};
      vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h10,       32'h99999999, 5'd11, 1'b1, 32'h22222222, 1'b1, 1'b1, 32'h10};
      vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h10,       32'h0,        5'd12, 1'b1, 32'h22222222, 1'b0, 1'b1, 32'h22222222};

      // Power-up reset with random traffic on the M side.
      rst = 1'b0;
      drive(1'b1, 1'($urandom), 1'b1, $urandom, $urandom, 5'($urandom));
      #1;
      check_all_zero("por_async");
      for (int i = 0; i < 2; i++) begin
         drive(1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom));
         step();
         check_all_zero("por_edge");
      end
      $display("txn por: outputs held at zero during reset");
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      rst = 1'b1;

      // Directed vector table.
      for (int v = 0; v < 13; v++) begin
         drive(vecs[v].rw, vecs[v].m2r, vecs[v].mw, vecs[v].alu, vecs[v].wd, vecs[v].wr);
         step();
         if (vecs[v].chk_rd) chk($sformatf("vec%0d.ReadDataW", v), bus.ReadDataW, vecs[v].exp_rd);
         chk($sformatf("vec%0d.RegWriteW", v), 32'(bus.RegWriteW), 32'(vecs[v].exp_rw));
         chk($sformatf("vec%0d.MemtoRegW", v), 32'(bus.MemtoRegW), 32'(vecs[v].m2r));
         chk($sformatf("vec%0d.AluOutW", v),   bus.AluOutW,          vecs[v].alu);
         chk($sformatf("vec%0d.WriteRegW", v), 32'(bus.WriteRegW), 32'(vecs[v].wr));
         chk($sformatf("vec%0d.ResultW", v),   bus.ResultW,          vecs[v].exp_res);
         chk($sformatf("vec%0d.AlignErr", v),  32'(bus.AlignErr),  32'(vecs[v].exp_err));
         $display("txn vec%0d: alu=%h mw=%0b m2r=%0b rd=%h res=%h err=%0b",
                  v, vecs[v].alu, vecs[v].mw, vecs[v].m2r, bus.ReadDataW, bus.ResultW, bus.AlignErr);
      end

      // Mid-cycle reset: outputs clear at once, stores to word 4 are blocked.
      drive(1'b1, 1'b0, 1'b1, 32'h10, 32'h55555555, 5'd1);
      rst = 1'b0;
      #1;
      check_all_zero("rst_async");
      for (int i = 0; i < 3; i++) begin
         drive(1'($urandom), 1'($urandom), 1'b1, 32'h10, $urandom, 5'($urandom));
         step();
         check_all_zero("rst_edge");
      end
      drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd7);
      #2;
      rst = 1'b1;
      step();
      chk("rst_nowrite.ReadDataW", bus.ReadDataW, 32'h22222222);
      chk("rst_nowrite.ResultW",   bus.ResultW,   32'h22222222);
      chk("rst_nowrite.RegWriteW", 32'(bus.RegWriteW), 32'd1);
      chk("rst_nowrite.WriteRegW", 32'(bus.WriteRegW), 32'd7);
      chk("rst_nowrite.AlignErr",  32'(bus.AlignErr),  32'd0);
      $display("txn rst: mid-cycle reset, memory word 4 = %h after release", bus.ReadDataW);

      // Randomized traffic against the reference model.
      for (int k = 0; k < 256; k++) begin
         mdl_known[k] = 1'b0;
         mdl_mem[k]   = 32'h0;
      end
      mdl_err = 1'b0;
      for (int t = 0; t < 200; t++) begin
         int          op;
         logic        rw, m2r, mw, mis, e_rw, e_err, rd_known, res_known;
         logic [31:0] alu, wd, e_rd, e_res;
         logic [4:0]  wr;
         int          widx;

         op  = int'($urandom_range(0, 9));
         mw  = (op < 4);
         m2r = (op >= 4) && (op < 8);
         rw  = 1'($urandom);
         wd  = $urandom;
         wr  = 5'($urandom);
         if (op >= 8) begin
            alu = $urandom;
         end else begin
            alu = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 7) * 5) << 2);
            if ($urandom_range(0, 9) == 0) alu = alu | 32'($urandom_range(1, 3));
         end

         mis       = (mw || m2r) && (alu % 4 != 0);
         widx      = int'((alu / 4) % 256);
         rd_known  = mdl_known[widx];
         e_rd      = mdl_mem[widx];
         e_rw      = rw && !mis;
         e_err     = mdl_err || mis;
         e_res     = m2r ? e_rd : alu;
         res_known = m2r ? rd_known : 1'b1;

         drive(rw, m2r, mw, alu, wd, wr);
         step();
         if (rd_known)  chk($sformatf("rnd%0d.ReadDataW", t), bus.ReadDataW, e_rd);
         if (res_known) chk($sformatf("rnd%0d.ResultW", t),   bus.ResultW,   e_res);
         chk($sformatf("rnd%0d.RegWriteW", t), 32'(bus.RegWriteW), 32'(e_rw));
         chk($sformatf("rnd%0d.MemtoRegW", t), 32'(bus.MemtoRegW), 32'(m2r));
         chk($sformatf("rnd%0d.AluOutW", t),   bus.AluOutW,          alu);
         chk($sformatf("rnd%0d.WriteRegW", t), 32'(bus.WriteRegW), 32'(wr));
         chk($sformatf("rnd%0d.AlignErr", t),  32'(bus.AlignErr),  32'(e_err));
         $display("txn rnd%0d: alu=%h mw=%0b m2r=%0b mis=%0b rd=%h res=%h",
                  t, alu, mw, m2r, mis, bus.ReadDataW, bus.ResultW);

         if (mw && !mis) begin
            mdl_mem[widx]   = wd;
            mdl_known[widx] = 1'b1;
         end
         mdl_err = e_err;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage plus MEM/WB pipeline register of the pipelined MIPS core. Consumes the EX/MEM register outputs (`*M` signals), performs word loads and stores against an internal data memory, and registers the results into the writeback stage (`*W` signals). Also produces the writeback result mux output `ResultW`, which feeds the register file and the forwarding path.

## Interface
- `DEPTH`, 256: data memory size in 32-bit words; power of two, 4..65536.
- `AW`, `$clog2(DEPTH)`: word-index width; derived, not overridden.

Ports (name, direction, width, meaning):
- `clk`  in  1  core clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `RegWriteM`  in  1  register write enable from EX/MEM.
- `MemtoRegM`  in  1  select load data for writeback.
- `MemWriteM`  in  1  store request.
- `AluOutM`  in  32  byte address for load/store; ALU result otherwise.
- `WriteDataM`  in  32  store data.
- `WriteRegM`  in  5  destination register.
- `RegWriteW`  out  1  registered, qualified write enable.
- `MemtoRegW`  out  1  registered `MemtoRegM`.
- `ReadDataW`  out  32  registered load data.
- `AluOutW`  out  32  registered `AluOutM`.
- `WriteRegW`  out  5  registered `WriteRegM`.
- `ResultW`  out  32  `MemtoRegW ? ReadDataW : AluOutW` (combinational).
- `AlignErr`  out  1  sticky misaligned-access flag.

## Operation
- Word index: `AluOutM[AW+1:2]`. Upper address bits are ignored, so addresses wrap modulo `DEPTH*4`.
- Misaligned access: `(MemWriteM | MemtoRegM) & (AluOutM[1:0] != 0)`.
- Store: when `MemWriteM` is high, the access is aligned, and `rst` is high, `mem[idx] <= WriteDataM` at the rising edge. A misaligned store writes nothing.
- Load: the memory is read combinationally at `idx` and captured into `ReadDataW` at the edge. `ReadDataW` is captured every cycle, regardless of `MemtoRegM`.
- A misaligned load or store forces `RegWriteW <= 0` for that instruction.
  - The other W fields are still captured.
  - `AlignErr` is set to 1 and stays set until reset.
- Otherwise `RegWriteW <= RegWriteM` and all W fields copy their M inputs every cycle. There is no stall or flush.
- Reset (`rst` low) immediately clears `RegWriteW`, `MemtoRegW`, `ReadDataW`, `AluOutW`, `WriteRegW` and `AlignErr` to 0. `ResultW` is therefore 0.
- Memory contents are not affected by reset and are undefined after power-up.

## Timing
- Latency: M inputs to W outputs in 1 cycle. A store is visible to a load one cycle after the store's edge.
- Read-during-write to the same index in the same cycle: the load captures the OLD word (read-before-write).
- Back-to-back stores to the same index: the last one wins.
- Reset asserted mid-cycle: outputs clear asynchronously, and no store occurs at any edge while `rst` is low.
- Reset release: the first capture happens at the first rising edge with `rst` high.
- `ResultW` settles combinationally from the W registers and has no extra latency.

## Structure
- Shared package `mips_pkg`: `WORD_W = 32`, `REG_AW = 5`. `memory_reg` and this block use these constants.
- Sub-module `data_mem`, parameterised by `DEPTH`:
  - interface: `clk`, `rst`, `we`, `idx[AW-1:0]`, `wd[31:0]`, `rd[31:0]`;
  - combinational read, synchronous write gated by `rst`.
- The top level holds the misalignment logic, the W register bank, the `AlignErr` flop and the `ResultW` mux.

## Test plan
- **Reset:** drive `rst = 0` with random M inputs → all W outputs, `ResultW` and `AlignErr` read 0, and there are no writes.
- **Store then load:**
  - store `0xDEADBEEF` to `0x10`, then load `0x10` with `MemtoRegM = 1`, `RegWriteM = 1`, `WriteRegM = 8`;
  - → one cycle after the load, `ReadDataW = ResultW = 0xDEADBEEF`, `WriteRegW = 8`, `RegWriteW = 1`.
- **Read-during-write:**
  - with `mem[4] = 0x11111111`, drive `AluOutM = 0x10`, `MemWriteM = 1`, `WriteDataM = 0x22222222` (word index 4) → `ReadDataW = 0x11111111`;
  - the next load of `0x10` → `0x22222222`.
- **Misaligned:** store to `0x13`, then load `0x10` → data unchanged. Then load `0x12` with `RegWriteM = 1` → `RegWriteW = 0`, `AlignErr = 1` and stays set until reset.
- **ALU pass-through:** `MemtoRegM = 0`, `AluOutM = 0x12345678`, `RegWriteM = 1` → `ResultW = 0x12345678`, and the memory is untouched.
- **Wrap:** with `DEPTH = 256`, store `0xA5A5A5A5` at `0x400` → a load of `0x000` returns `0xA5A5A5A5`.
